// File: rtl/ws2812_stream_decoder.sv
// ws2812_stream_decoder
//   Receive-side decoder for a WS2812B-style single-wire LED stream.
//   The line is sampled at the 40 MHz system clock. Each high pulse is decoded
//   into one bit by its width. Bits are assembled LSB-first into 24-bit pixels.
//   A long low period (latch/reset gap) marks a frame boundary.
//   Malformed pulses raise a one-cycle err together with a cause code.
//
// Ports
//   clk          in   40 MHz system clock
//   reset        in   synchronous, active-high
//   din          in   asynchronous serial line (synchronised internally)
//   enable       in   low = hold in WAIT_GAP and ignore din
//   pixel_data   out  last completed pixel, bit 0 = first bit received
//   pixel_valid  out  one-cycle pulse when pixel_data updates
//   pixel_count  out  pixels completed in the current frame (saturating)
//   frame_done   out  one-cycle pulse at a gap that ends a non-empty frame
//   err          out  one-cycle pulse on a protocol violation
//   err_code     out  cause of last error: 01 short high, 10 long high,
//                     11 short low, 00 truncated pixel
//   dbg_state    out  current FSM state (0 WAIT_GAP, 1 IDLE, 2 HIGH, 3 LOW)
//
// Output handshake: pixel_valid, frame_done and err are single-cycle strobes
// with no back-pressure. pixel_data, pixel_count and err_code are stable
// whenever their strobe is high, and the consumer must sample them in that
// cycle.
module ws2812_stream_decoder #(
    parameter int BIT_THRESH   = 25,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 48,
    parameter int MIN_LOW      = 8,
    parameter int RESET_CYCLES = 1600,
    parameter int PIX_W        = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             enable,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [PIX_W-1:0] pixel_count,
    output logic             frame_done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [1:0]       dbg_state
);

    // Counter widths are chosen so that the saturation value lies strictly
    // beyond the largest value that is compared against.
    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    localparam logic [1:0] S_WAIT_GAP = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_LOW      = 2'd3;

    logic [1:0]    state;
    logic          sync1;
    logic          din_s;
    logic          din_s_d;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_now;
    logic [LW-1:0] lcnt_q;
    logic [LW-1:0] lcnt_now;
    logic [4:0]    bitcnt;
    logic [23:0]   shreg;
    logic          rise;
    logic          fall;
    logic          gap_hit;
    logic          bit_val;

    assign dbg_state = state;

    // Two-flop synchroniser, plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            din_s   <= 1'b0;
            din_s_d <= 1'b0;
        end else begin
            sync1   <= din;
            din_s   <= sync1;
            din_s_d <= din_s;
        end
    end

    assign rise = din_s & ~din_s_d;
    assign fall = ~din_s & din_s_d;

    // hcnt_now/lcnt_now are the run lengths including the current cycle.
    // On a fall, hcnt_q still holds the width of the pulse that just ended.
    // On a rise, lcnt_q still holds the width of the low that just ended.
    always_comb begin
        hcnt_now = '0;
        lcnt_now = '0;
        if (enable) begin
            if (din_s) begin
                if (!din_s_d)
                    hcnt_now = HW'(1);
                else if (hcnt_q == {HW{1'b1}})
                    hcnt_now = hcnt_q;
                else
                    hcnt_now = hcnt_q + HW'(1);
            end else begin
                if (din_s_d)
                    lcnt_now = LW'(1);
                else if (lcnt_q == {LW{1'b1}})
                    lcnt_now = lcnt_q;
                else
                    lcnt_now = lcnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
            lcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_now;
            lcnt_q <= lcnt_now;
        end
    end

    // Because lcnt saturates above RESET_CYCLES, equality fires exactly once
    // per low period.
    assign gap_hit = (lcnt_now == LW'(RESET_CYCLES));
    assign bit_val = (hcnt_q >= HW'(BIT_THRESH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_WAIT_GAP;
            bitcnt      <= '0;
            shreg       <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            if (!enable) begin
                state  <= S_WAIT_GAP;
                bitcnt <= '0;
            end else begin
                case (state)
                    S_WAIT_GAP: begin
                        if (gap_hit) begin
                            state       <= S_IDLE;
                            bitcnt      <= '0;
                            pixel_count <= '0;
                        end
                    end
                    S_IDLE: begin
                        // Clearing here lets pixel_count hold through the
                        // frame_done cycle and drop in the cycle after it.
                        pixel_count <= '0;
                        if (rise)
                            state <= S_HIGH;
                    end
                    S_HIGH: begin
                        if (hcnt_now > HW'(MAX_HIGH)) begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            state    <= S_WAIT_GAP;
                            bitcnt   <= '0;
                        end else if (fall) begin
                            if (hcnt_q < HW'(MIN_HIGH)) begin
                                err      <= 1'b1;
                                err_code <= 2'b01;
                                state    <= S_WAIT_GAP;
                                bitcnt   <= '0;
                            end else begin
                                shreg[bitcnt] <= bit_val;
                                state         <= S_LOW;
                                if (bitcnt == 5'd23) begin
                                    pixel_data  <= {bit_val, shreg[22:0]};
                                    pixel_valid <= 1'b1;
                                    bitcnt      <= '0;
                                    if (pixel_count != {PIX_W{1'b1}})
                                        pixel_count <= pixel_count + PIX_W'(1);
                                end else begin
                                    bitcnt <= bitcnt + 5'd1;
                                end
                            end
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            if (lcnt_q < LW'(MIN_LOW)) begin
                                err      <= 1'b1;
                                err_code <= 2'b11;
                                state    <= S_WAIT_GAP;
                                bitcnt   <= '0;
                            end else begin
                                state <= S_HIGH;
                            end
                        end else if (gap_hit) begin
                            state <= S_IDLE;
                            if (bitcnt != 5'd0) begin
                                // Gap arrived mid-pixel: the frame is unusable.
                                err         <= 1'b1;
                                err_code    <= 2'b00;
                                bitcnt      <= '0;
                                pixel_count <= '0;
                            end else begin
                                frame_done <= (pixel_count != '0);
                            end
                        end
                    end
                    default: state <= S_WAIT_GAP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ws2812_stream_decoder.sv
`timescale 1ns/1ps
module tb_ws2812_stream_decoder;

  logic        clk;
  logic        reset;
  logic        din;
  logic        enable;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [6:0]  pixel_count;
  logic        frame_done;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;

  // bit timing in clk cycles (changed for the long back-to-back run)
  int t0h, t0l, t1h, t1l;

  logic [23:0] exp_q[$];
  logic [6:0]  exp_frame_q[$];
  logic [1:0]  exp_err_q[$];

  ws2812_stream_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .enable      (enable),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .err         (err),
    .err_code    (err_code),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // driver tasks; all run from #1 after a rising edge
  task automatic send_pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) begin @(posedge clk); #1; end
    din = 1'b0;
    repeat (l) begin @(posedge clk); #1; end
  endtask

  task automatic send_low(input int n);
    din = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(t1h, t1l);
    else   send_pulse(t0h, t0l);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    send_bits(w, 24);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid && err) fail_event("valid_with_err");
      if (pixel_valid) begin
        if (exp_q.size() == 0) fail_event("pixel_valid_unexpected");
        else check("pixel_data", 32'(pixel_data), 32'(exp_q.pop_front()));
      end
      if (frame_done) begin
        if (exp_frame_q.size() == 0) fail_event("frame_done_unexpected");
        else check("frame_pixel_count", 32'(pixel_count), 32'(exp_frame_q.pop_front()));
      end
      if (err) begin
        if (exp_err_q.size() == 0) fail_event("err_unexpected");
        else check("err_code", 32'(err_code), 32'(exp_err_q.pop_front()));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    t0h = 17; t0l = 35; t1h = 33; t1l = 19;
    din    = 1'b0;
    enable = 1'b1;
    reset  = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_pixel_data",  32'(pixel_data),  32'h0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    check("rst_pixel_count", 32'(pixel_count), 32'h0);
    check("rst_frame_done",  32'(frame_done),  32'h0);
    check("rst_err",         32'(err),         32'h0);
    check("rst_err_code",    32'(err_code),    32'h0);
    check("rst_state",       32'(dbg_state),   32'h0);
    @(posedge clk); #1;

    // valid bits before any gap are ignored
    send_pixel(24'h123456);
    send_low(1700);
    check("idle_after_gap", 32'(dbg_state), 32'h1);
    check("count_after_first_gap", 32'(pixel_count), 32'h0);

    // single pixel frame
    exp_q.push_back(24'h00b000);
    send_pixel(24'h00b000);
    check("count_one", 32'(pixel_count), 32'h1);
    exp_frame_q.push_back(7'd1);
    send_low(1700);
    check("count_cleared", 32'(pixel_count), 32'h0);

    // 65 back-to-back pixels, tighter legal timing
    t0h = 10; t0l = 8; t1h = 26; t1l = 8;
    for (int p = 0; p < 65; p++) begin
      logic [23:0] w;
      w = (p % 2 == 0) ? 24'h00f060 : 24'h0000b0;
      exp_q.push_back(w);
      send_pixel(w);
    end
    check("count_65", 32'(pixel_count), 32'd65);
    exp_frame_q.push_back(7'd65);
    send_low(1700);
    t0h = 17; t0l = 35; t1h = 33; t1l = 19;

    // boundary high widths: 24 -> 0, 25 -> 1
    exp_q.push_back(24'h000002);
    send_pulse(24, 30);
    send_pulse(25, 30);
    send_bits(24'h000000, 22);
    exp_frame_q.push_back(7'd1);
    send_low(1700);

    // short high
    exp_err_q.push_back(2'b01);
    send_pulse(7, 30);
    check("state_after_short_high", 32'(dbg_state), 32'h0);
    send_low(1700);

    // stuck high
    exp_err_q.push_back(2'b10);
    send_pulse(49, 30);
    send_low(1700);

    // short low between bits, then recovery
    exp_err_q.push_back(2'b11);
    send_pulse(17, 7);
    send_pulse(17, 35);
    send_bits(24'h000007, 3);
    send_low(1700);
    exp_q.push_back(24'ha5c3e1);
    send_pixel(24'ha5c3e1);
    exp_frame_q.push_back(7'd1);
    send_low(1700);

    // truncated pixel
    exp_q.push_back(24'h3c3c3c);
    send_pixel(24'h3c3c3c);
    check("count_before_trunc", 32'(pixel_count), 32'h1);
    exp_err_q.push_back(2'b00);
    send_bits(24'hffffff, 12);
    send_low(1700);
    check("count_after_trunc", 32'(pixel_count), 32'h0);

    // enable dropped mid-pixel
    exp_q.push_back(24'h5a5a5a);
    send_pixel(24'h5a5a5a);
    send_bits(24'h0003ff, 10);
    enable = 1'b0;
    send_low(20);
    check("en_off_state", 32'(dbg_state), 32'h0);
    check("en_off_data", 32'(pixel_data), 32'h5a5a5a);
    enable = 1'b1;
    send_bits(24'h003fff, 14);
    send_low(1700);
    check("en_data_held", 32'(pixel_data), 32'h5a5a5a);
    check("en_count", 32'(pixel_count), 32'h0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pixels_left", 32'(exp_q.size()), 32'h0);
    check("frames_left", 32'(exp_frame_q.size()), 32'h0);
    check("errs_left",   32'(exp_err_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
